systolic_out_collector: RTL and testbench
=========================================

Name: systolic_out_collector

Overview:
Downstream stage of the 5x5 systolic array. It takes the column partial-sum outputs (o_acc_kernel of the array), which arrive skewed by one cycle per column. It deskews them into one aligned output row and buffers rows in a small FIFO. Rows leave through a valid/ready interface to the writeback/requant stage. The array cannot be stalled, so overflow is detected and flagged, never back-pressured.

Parameters:
AK_BW, 20, width of one column accumulated result (signed, passed unmodified)
COLS, 5, number of array columns
DEPTH, 4, FIFO depth in rows (power of 2, >=2)
CNT_BW, 16, width of the row counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_acc_kernel  input  AK_BW*COLS  array column results; column c in slice [(c+1)*AK_BW-1 -: AK_BW]
i_vld  input  1  column-0 result of a new row valid this cycle; column c is valid c cycles later
i_clr  input  1  clears o_ovf and o_row_cnt
o_data  output  AK_BW*COLS  aligned row at FIFO head, same column packing as input
o_vld  output  1  o_data valid
i_rdy  input  1  consumer accepts o_data when o_vld&i_rdy
o_full  output  1  FIFO holds DEPTH rows
o_ovf  output  1  sticky: a completed row was dropped
o_row_cnt  output  CNT_BW  rows written into FIFO, wraps modulo 2^CNT_BW

Behaviour:
- Reset (rst=1 at posedge): the valid shift register, deskew registers, FIFO pointers and count, o_ovf and o_row_cnt all go to 0. o_vld=0, o_full=0, o_data=0. In-flight rows are discarded, and no o_vld results from them after rst deasserts.
- Valid pipeline: vsr[0]=i_vld; vsr[k]=vsr[k-1] delayed 1 cycle, for k=1..COLS-1. Row write strobe wr = vsr[COLS-1].
- Deskew: column c passes through COLS-1-c registers, which are enabled every cycle. Column COLS-1 is used directly.
- Timing: for i_vld at cycle T, column c is sampled at T+c. The aligned row is presented to the FIFO at T+COLS-1 and written at that edge.
- Latency: if the FIFO is empty, o_vld rises at T+COLS (5 cycles for the default).
- Rows may be issued back-to-back (i_vld every cycle). The block sustains 1 row/cycle when i_rdy=1.
- FIFO:
  - count 0..DEPTH; wr_ptr/rd_ptr wrap modulo DEPTH.
  - pop = o_vld & i_rdy. push = wr & (count<DEPTH | pop).
  - Push and pop in the same cycle: count is unchanged and both pointers advance. This applies in both the full and the non-empty cases.
  - Empty with push: there is no bypass; data is visible the next cycle.
  - o_vld = (count!=0). o_data = mem[rd_ptr] when o_vld, else 0. o_full = (count==DEPTH).
  - o_data is held stable while o_vld & !i_rdy.
- Overflow: when wr & count==DEPTH & !pop, the row is dropped, o_ovf is set, and o_row_cnt does not increment.
- o_row_cnt increments on every push and wraps from 2^CNT_BW-1 to 0.
- i_clr: o_ovf and o_row_cnt are cleared to 0 at the next edge. If a push occurs in the same cycle, o_row_cnt becomes 1. If an overflow occurs in the same cycle, o_ovf stays 1, because set wins over clear. FIFO contents are unaffected by i_clr.
- Arithmetic: none. Bits pass through unmodified, including sign.

Test Plan:
- Single row: i_vld at cycle 10, column c = 100+c at cycle 10+c, i_rdy=1 -> o_vld high only in cycle 15, o_data columns {100,101,102,103,104}, o_row_cnt=1, o_ovf=0.
- Fill/overflow: 5 back-to-back rows (row k, column c = 10k+c), i_rdy=0 -> o_full=1 after the 4th write and o_ovf=1 after the 5th. o_row_cnt=4. With i_rdy=1, rows 0..3 drain in order and row 4 never appears.
- Full with simultaneous pop: FIFO full, i_rdy=1 in the cycle a 5th row completes -> row accepted, count stays 4, o_ovf=0, o_row_cnt increments to 5.
- Reset mid-flight: i_vld at T, rst=1 at T+2 for 1 cycle -> o_vld stays 0 for 20 cycles, and all outputs are 0 from T+3.
- Wrap/stream: 10 consecutive rows with i_rdy=1 -> 10 o_vld cycles from T+5 to T+14, in order, and pointers wrap twice. Also send column values 20'h80000 and 20'h7FFFF -> output bit-identical to input.
- i_clr: assert i_clr in the same cycle as a push while o_ovf=1 -> next cycle o_ovf=0 and o_row_cnt=1.

Source files
------------

// File: rtl/systolic_out_collector_if.sv
// systolic_out_collector_if: column-result input and aligned-row valid/ready output bundle
interface systolic_out_collector_if #(
  parameter int AK_BW  = 20,
  parameter int COLS   = 5,
  parameter int CNT_BW = 16
);
  logic [AK_BW*COLS-1:0] i_acc_kernel;
  logic                  i_vld;
  logic                  i_clr;
  logic [AK_BW*COLS-1:0] o_data;
  logic                  o_vld;
  logic                  i_rdy;
  logic                  o_full;
  logic                  o_ovf;
  logic [CNT_BW-1:0]     o_row_cnt;
  modport master (
    output i_acc_kernel, i_vld, i_clr, i_rdy,
    input  o_data, o_vld, o_full, o_ovf, o_row_cnt
  );
  modport slave (
    input  i_acc_kernel, i_vld, i_clr, i_rdy,
    output o_data, o_vld, o_full, o_ovf, o_row_cnt
  );
endinterface

// File: rtl/systolic_out_collector.sv
// systolic_out_collector: deskews skewed systolic column results into rows and buffers them in a FIFO
module systolic_out_collector #(
  parameter int AK_BW  = 20,
  parameter int COLS   = 5,
  parameter int DEPTH  = 4,
  parameter int CNT_BW = 16
) (
  input logic clk,
  input logic rst,
  systolic_out_collector_if.slave bus
);
  localparam int W  = AK_BW * COLS;
  localparam int PW = $clog2(DEPTH);
  logic [COLS-1:1] vsr;
  logic            wr;
  logic [W-1:0]    row;
  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     cnt;
  logic            full, pop, push;
  logic            ovf;
  logic [CNT_BW-1:0] row_cnt;
  always_ff @(posedge clk)
    vsr <= rst ? '0 : {vsr[COLS-2:1], bus.i_vld};
  assign wr = vsr[COLS-1];
  // column c waits COLS-1-c cycles so every column lands with the last one
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS - 1) begin : g_direct
      assign row[(c+1)*AK_BW-1 -: AK_BW] = bus.i_acc_kernel[(c+1)*AK_BW-1 -: AK_BW];
    end else begin : g_dly
      logic [AK_BW-1:0] d [COLS-1-c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < COLS - 1 - c; k++) d[k] <= '0;
        end else begin
          d[0] <= bus.i_acc_kernel[(c+1)*AK_BW-1 -: AK_BW];
          for (int k = 1; k < COLS - 1 - c; k++) d[k] <= d[k-1];
        end
      end
      assign row[(c+1)*AK_BW-1 -: AK_BW] = d[COLS-2-c];
    end
  end
  assign full = cnt == (PW+1)'(DEPTH);
  assign pop  = bus.o_vld & bus.i_rdy;
  assign push = wr & (!full | pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= row;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      row_cnt <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push);
      rd_ptr  <= rd_ptr + PW'(pop);
      cnt     <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      // a drop in the same cycle as a clear keeps the flag set
      ovf     <= (wr & full & !pop) | (ovf & !bus.i_clr);
      row_cnt <= (bus.i_clr ? '0 : row_cnt) + CNT_BW'(push);
    end
  end
  assign bus.o_vld     = cnt != '0;
  assign bus.o_data    = bus.o_vld ? mem[rd_ptr] : '0;
  assign bus.o_full    = full;
  assign bus.o_ovf     = ovf;
  assign bus.o_row_cnt = row_cnt;
endmodule

// File: tb/tb_systolic_out_collector.sv
// tb_systolic_out_collector: directed scenario tasks with hand-computed expected rows
module tb_systolic_out_collector;
  localparam int AK_BW = 20, COLS = 5, DEPTH = 4, CNT_BW = 16;
  localparam int W = AK_BW * COLS;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nerr = 0;
  logic         hv [COLS];
  logic [W-1:0] hr [COLS];
  systolic_out_collector_if #(.AK_BW(AK_BW), .COLS(COLS), .CNT_BW(CNT_BW)) bus ();
  systolic_out_collector #(.AK_BW(AK_BW), .COLS(COLS), .DEPTH(DEPTH), .CNT_BW(CNT_BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] mk(input int b);
    logic [W-1:0] r;
    for (int c = 0; c < COLS; c++) r[(c+1)*AK_BW-1 -: AK_BW] = AK_BW'(b + c);
    return r;
  endfunction
  // one cycle: row r launched now, column c carries the row launched c cycles ago
  task automatic tick(input logic v, input logic [W-1:0] r, input logic rdy, input logic clr, input logic rs);
    for (int c = COLS - 1; c > 0; c--) begin
      hv[c] = hv[c-1];
      hr[c] = hr[c-1];
    end
    hv[0] = v;
    hr[0] = r;
    bus.i_vld = v;
    bus.i_rdy = rdy;
    bus.i_clr = clr;
    rst = rs;
    for (int c = 0; c < COLS; c++)
      bus.i_acc_kernel[(c+1)*AK_BW-1 -: AK_BW] = hv[c] ? hr[c][(c+1)*AK_BW-1 -: AK_BW] : '0;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    for (int c = 0; c < COLS; c++) begin
      hv[c] = 1'b0;
      hr[c] = '0;
    end
    tick(0, '0, 0, 0, 1);
    tick(0, '0, 0, 0, 1);
    tick(0, '0, 0, 0, 0);
  endtask
  task automatic test_reset();
    do_reset();
    nvec++;
    if ({bus.o_vld, bus.o_full, bus.o_ovf} !== 3'b000 || bus.o_data !== '0 || bus.o_row_cnt !== '0) begin
      nerr++;
      $display("FAIL reset: vld/full/ovf=%b data=%h cnt=%0d, required 000/0/0",
               {bus.o_vld, bus.o_full, bus.o_ovf}, bus.o_data, bus.o_row_cnt);
    end
  endtask
  task automatic test_single_row();
    logic [W-1:0] r;
    r = mk(100);
    do_reset();
    tick(1, r, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, '0, 1, 0, 0);
    nvec++;
    if (bus.o_vld !== 1'b0) begin
      nerr++;
      $display("FAIL single_early: o_vld=%b required 0 at T+4", bus.o_vld);
    end
    tick(0, '0, 1, 0, 0);
    nvec++;
    if (bus.o_vld !== 1'b1 || bus.o_data !== r || bus.o_row_cnt !== 16'd1 || bus.o_ovf !== 1'b0) begin
      nerr++;
      $display("FAIL single_row: vld=%b data=%h cnt=%0d ovf=%b, required 1 %h 1 0",
               bus.o_vld, bus.o_data, bus.o_row_cnt, bus.o_ovf, r);
    end
    tick(0, '0, 1, 0, 0);
    nvec++;
    if (bus.o_vld !== 1'b0 || bus.o_data !== '0) begin
      nerr++;
      $display("FAIL single_after: vld=%b data=%h, required 0 0", bus.o_vld, bus.o_data);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) tick(1, mk(10 * k), 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, '0, 0, 0, 0);
    nvec++;
    if (bus.o_full !== 1'b1 || bus.o_ovf !== 1'b0 || bus.o_row_cnt !== 16'd4) begin
      nerr++;
      $display("FAIL fill4: full=%b ovf=%b cnt=%0d, required 1 0 4", bus.o_full, bus.o_ovf, bus.o_row_cnt);
    end
    tick(0, '0, 0, 0, 0);
    nvec++;
    if (bus.o_full !== 1'b1 || bus.o_ovf !== 1'b1 || bus.o_row_cnt !== 16'd4 || bus.o_data !== mk(0)) begin
      nerr++;
      $display("FAIL overflow: full=%b ovf=%b cnt=%0d data=%h, required 1 1 4 %h",
               bus.o_full, bus.o_ovf, bus.o_row_cnt, bus.o_data, mk(0));
    end
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (bus.o_vld !== 1'b1 || bus.o_data !== mk(10 * k)) begin
        nerr++;
        $display("FAIL drain%0d: vld=%b data=%h, required 1 %h", k, bus.o_vld, bus.o_data, mk(10 * k));
      end
      tick(0, '0, 1, 0, 0);
    end
    nvec++;
    if (bus.o_vld !== 1'b0 || bus.o_full !== 1'b0 || bus.o_ovf !== 1'b1) begin
      nerr++;
      $display("FAIL drained: vld=%b full=%b ovf=%b, required 0 0 1", bus.o_vld, bus.o_full, bus.o_ovf);
    end
  endtask
  task automatic test_full_pop();
    do_reset();
    for (int k = 0; k < 5; k++) tick(1, mk(10 * k), 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, '0, 0, 0, 0);
    nvec++;
    if (bus.o_full !== 1'b1 || bus.o_data !== mk(0)) begin
      nerr++;
      $display("FAIL full_hold: full=%b data=%h, required 1 %h", bus.o_full, bus.o_data, mk(0));
    end
    tick(0, '0, 1, 0, 0);
    nvec++;
    if (bus.o_full !== 1'b1 || bus.o_ovf !== 1'b0 || bus.o_row_cnt !== 16'd5 || bus.o_data !== mk(10)) begin
      nerr++;
      $display("FAIL full_pop: full=%b ovf=%b cnt=%0d data=%h, required 1 0 5 %h",
               bus.o_full, bus.o_ovf, bus.o_row_cnt, bus.o_data, mk(10));
    end
    for (int k = 1; k < 5; k++) begin
      nvec++;
      if (bus.o_vld !== 1'b1 || bus.o_data !== mk(10 * k)) begin
        nerr++;
        $display("FAIL full_pop_drain%0d: vld=%b data=%h, required 1 %h", k, bus.o_vld, bus.o_data, mk(10 * k));
      end
      tick(0, '0, 1, 0, 0);
    end
  endtask
  task automatic test_reset_midflight();
    int bad;
    bad = 0;
    tick(1, mk(500), 1, 0, 0);
    tick(0, '0, 1, 0, 0);
    tick(0, '0, 1, 0, 1);
    nvec++;
    if ({bus.o_vld, bus.o_full, bus.o_ovf} !== 3'b000 || bus.o_data !== '0 || bus.o_row_cnt !== '0) begin
      nerr++;
      $display("FAIL reset_mid: vld/full/ovf=%b data=%h cnt=%0d, required 000/0/0",
               {bus.o_vld, bus.o_full, bus.o_ovf}, bus.o_data, bus.o_row_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, '0, 1, 0, 0);
      if (bus.o_vld !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL reset_mid_quiet: %0d cycles with o_vld=1, required 0", bad);
    end
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] rows [10];
    for (int k = 0; k < 10; k++) rows[k] = mk(1000 * k);
    for (int c = 0; c < COLS; c++) begin
      rows[3][(c+1)*AK_BW-1 -: AK_BW] = 20'h80000;
      rows[6][(c+1)*AK_BW-1 -: AK_BW] = (c % 2 == 0) ? 20'h7FFFF : 20'h80000;
    end
    do_reset();
    for (int i = 0; i < 15; i++) begin
      tick(i < 10, i < 10 ? rows[i] : '0, 1, 0, 0);
      if (i < 4 || i == 14) begin
        nvec++;
        if (bus.o_vld !== 1'b0) begin
          nerr++;
          $display("FAIL stream_idle%0d: o_vld=%b required 0", i, bus.o_vld);
        end
      end else begin
        nvec++;
        if (bus.o_vld !== 1'b1 || bus.o_data !== rows[i-4]) begin
          nerr++;
          $display("FAIL stream_row%0d: vld=%b data=%h, required 1 %h", i - 4, bus.o_vld, bus.o_data, rows[i-4]);
        end
      end
    end
    nvec++;
    if (bus.o_row_cnt !== 16'd10 || bus.o_ovf !== 1'b0) begin
      nerr++;
      $display("FAIL stream_cnt: cnt=%0d ovf=%b, required 10 0", bus.o_row_cnt, bus.o_ovf);
    end
  endtask
  task automatic test_clr();
    do_reset();
    for (int k = 0; k < 6; k++) tick(1, mk(10 * k), 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, '0, 0, 0, 0);
    nvec++;
    if (bus.o_ovf !== 1'b1 || bus.o_row_cnt !== 16'd4) begin
      nerr++;
      $display("FAIL clr_pre: ovf=%b cnt=%0d, required 1 4", bus.o_ovf, bus.o_row_cnt);
    end
    tick(0, '0, 1, 1, 0);
    nvec++;
    if (bus.o_ovf !== 1'b0 || bus.o_row_cnt !== 16'd1 || bus.o_full !== 1'b1 || bus.o_data !== mk(10)) begin
      nerr++;
      $display("FAIL clr_push: ovf=%b cnt=%0d full=%b data=%h, required 0 1 1 %h",
               bus.o_ovf, bus.o_row_cnt, bus.o_full, bus.o_data, mk(10));
    end
  endtask
  initial begin
    bus.i_acc_kernel = '0;
    bus.i_vld = 1'b0;
    bus.i_clr = 1'b0;
    bus.i_rdy = 1'b0;
    test_reset();
    test_single_row();
    test_overflow();
    test_full_pop();
    test_reset_midflight();
    test_back_to_back();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
